score_display_engine: RTL and testbench
=======================================

Name: score_display_engine

Overview:
- Parametrised VGA score/timer renderer; successor to the fixed 3-digit score overlay.
- Converts a binary score to NUM_DIGITS BCD digits with a multi-cycle sequential converter.
- Commits new digits only at frame boundaries, so there is no tearing.
- Adds leading-zero blanking, saturation, and an update-blink effect.
- Drives `score_on` to the pixel mux through a 2-cycle pipeline aligned with the synchronous `numbers_rom`.

Parameters:
- NUM_DIGITS, 3: digits displayed (1..6).
- SCORE_W, 8: score input width (1..20).
- X0, 500: left pixel column of the most-significant digit.
- Y0, 96: top pixel row of the digits.
- BLANK_LZ, 1: if 1, blank leading zeros while playing.
- BLINK_FRAMES, 32: frames of blinking after a displayed value changes (0 disables blinking).

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: asynchronous active-low reset.
- playing_reg, in, 1: game running; 0 shows all-zero digits.
- score_valid, in, 1: one-cycle strobe; capture `score`.
- score, in, SCORE_W: binary score.
- frame_tick, in, 1: one-cycle pulse at the start of vertical blank.
- x, in, 10: VGA pixel column.
- y, in, 10: VGA pixel row.
- score_on, out, 1: pixel is digit foreground; lags x/y by 2 cycles.
- busy, out, 1: converter active or an update is pending.

Behaviour:
- Reset (reset==0, asynchronous):
  - Converter FSM goes to IDLE; pending flag and pending value are cleared.
  - Staged and displayed digits become 0; blink counter becomes 0.
  - Pipeline stage registers become 0, so `score_on`=0 and `busy`=0.
  - Reset during a conversion discards it; no partial digits are committed.
- Capture:
  - In IDLE, `score_valid` loads the shift register and FSM goes to CONVERT.
  - If `score_valid` arrives in CONVERT or DONE, the value goes into a one-deep pending register. A later strobe overwrites it (last value wins).
- Converter FSM (IDLE -> CONVERT -> DONE -> IDLE):
  - CONVERT runs exactly SCORE_W cycles of double-dabble: add 3 to any nibble >=5, then shift left.
  - DONE (1 cycle) writes the staged digits.
  - If the binary score > 10^NUM_DIGITS-1, staged digits saturate to all 9s.
  - From DONE, the FSM goes to CONVERT if pending (pending clears), else to IDLE.
  - `busy` = (state != IDLE) | pending.
- Frame commit:
  - On `frame_tick`, the displayed digits take the staged digits.
  - If the displayed value changes and BLINK_FRAMES>0, load the blink counter with BLINK_FRAMES; otherwise decrement it if nonzero.
  - `frame_tick` in the same cycle as DONE commits the previous staged value; the new value commits at the next tick.
- Blanking rules for digit k (k=0 is most significant):
  - Hidden while the blink counter is nonzero and counter[2]==1.
  - If BLANK_LZ and playing_reg: hidden when it and all more-significant digits are 0 and k != NUM_DIGITS-1.
  - If playing_reg==0: every digit reads 0, no leading-zero blanking, no blink.
- Pixel pipeline:
  - Digit box is X0 <= x < X0+16*NUM_DIGITS and Y0 <= y < Y0+16.
  - Stage 1 (registered):
    - inbox;
    - k = (x-X0)>>4;
    - col = (x-X0)[3:0];
    - row = digit_value*16 + (y-Y0), 8 bits;
    - blank flag.
  - Stage 1 `row` and `col` address `numbers_rom`; its color_data is valid one cycle later.
  - Stage 2 registers inbox and blank.
  - `score_on` = color_data & inbox_s2 & ~blank_s2.
  - Latency is exactly 2 cycles from x/y; the pipeline runs every cycle with no stalls.
  - x/y outside the box gives `score_on`=0 at t+2.
- Width rules:
  - All coordinate subtractions are 11-bit unsigned and guarded by the box compare.
  - BCD shift register is SCORE_W+4*NUM_DIGITS bits.

Decomposition:
- Package score_display_pkg:
  - GLYPH_W=16, GLYPH_H=16, ROM_ROWS=160.
  - Converter state encoding: IDLE, CONVERT, DONE.
  - Function max_score(NUM_DIGITS).
- Sub-module bcd_seq_converter (parametrised on SCORE_W and NUM_DIGITS): FSM plus shift register, with ports start, bin, done, bcd.
- Existing numbers_rom instantiated unchanged.

Test Plan:
- Reset:
  - Hold reset=0 mid-CONVERT, release.
  - Required: busy=0, score_on=0; after the next frame_tick, displayed digits are 000.
- Leading-zero blank (playing_reg=1, score=42, then frame_tick):
  - Displayed digits are 0,4,2.
  - x=500..515, y=96..111: score_on=0 for every pixel (hundreds digit blanked).
  - x=516, y=100: score_on equals ROM bit at row 4*16+4, col 0, two cycles later.
- Saturation (SCORE_W=11, score=1234):
  - busy is high for 11+1 cycles after capture.
  - Displayed digits are 999 after frame_tick.
- Back-to-back update:
  - score_valid with 10, then 2 cycles later with 77, then 3 cycles later with 5.
  - Required: conversions of 10 then 5 only (77 overwritten); after idle and frame_tick, display shows 5.
- No tearing:
  - score_valid 9 -> 8 mid-frame.
  - Required: pixel output still renders 9 until frame_tick, then 8.
- Blink and not-playing:
  - BLINK_FRAMES=32, displayed value changes.
  - Required: score_on suppressed on frames where counter[2]=1, normal after 32 ticks.
  - playing_reg=0: renders 000 regardless of score.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared constants, converter state encoding and helpers for the score renderer.
package score_display_pkg;

  localparam int GLYPH_W  = 16;
  localparam int GLYPH_H  = 16;
  localparam int ROM_ROWS = 160;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

  // Largest value representable with the given number of decimal digits.
  function automatic int unsigned max_score(input int unsigned num_digits);
    int unsigned m;
    m = 1;
    for (int i = 0; i < num_digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/numbers_rom.sv
// Synchronous glyph ROM: ten 16x16 seven-segment digits stacked vertically.
module numbers_rom (
  input  logic       clk,
  input  logic [7:0] row,
  input  logic [3:0] col,
  output logic       color_data
);

  function automatic logic glyph_pixel(input logic [7:0] r_addr, input logic [3:0] c);
    logic [6:0] seg;
    logic [3:0] r;
    logic h_top, h_mid, h_bot, h_cols, v_up, v_lo, left, right;
    r = r_addr[3:0];
    case (r_addr[7:4])
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    h_top  = (r >= 4'd1)  && (r <= 4'd2);
    h_mid  = (r >= 4'd7)  && (r <= 4'd8);
    h_bot  = (r >= 4'd13) && (r <= 4'd14);
    h_cols = (c >= 4'd3)  && (c <= 4'd12);
    v_up   = (r >= 4'd1)  && (r <= 4'd8);
    v_lo   = (r >= 4'd7)  && (r <= 4'd14);
    left   = (c >= 4'd2)  && (c <= 4'd3);
    right  = (c >= 4'd12) && (c <= 4'd13);
    return (seg[6] && h_top && h_cols) || (seg[5] && right && v_up) ||
           (seg[4] && right && v_lo)   || (seg[3] && h_bot && h_cols) ||
           (seg[2] && left && v_lo)    || (seg[1] && left && v_up) ||
           (seg[0] && h_mid && h_cols);
  endfunction

  // Registered read: data for an address appears one cycle later.
  always_ff @(posedge clk) begin
    color_data <= glyph_pixel(row, col);
  end

endmodule

// File: rtl/score_display_bcd_seq_converter.sv
// Sequential double-dabble binary to BCD converter with saturation.
module bcd_seq_converter
  import score_display_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    idle,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int          BCD_W = 4 * NUM_DIGITS;
  localparam int          SR_W  = SCORE_W + BCD_W;
  localparam int          CNT_W = $clog2(SCORE_W + 1);
  localparam int unsigned MAX   = max_score(NUM_DIGITS);

  conv_state_t      state, state_nxt;
  logic [SR_W-1:0]  sr, adj, sr_step;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             load;

  assign load = start && ((state == IDLE) || (state == DONE));

  // State register; reset abandons any conversion in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: SCORE_W shift steps, one DONE cycle, then restart or idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONVERT;
      CONVERT: if (cnt == CNT_W'(SCORE_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = start ? CONVERT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to BCD nibbles >= 5, then shift left.
  always_comb begin
    adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[SCORE_W+4*i +: 4] >= 4'd5)
        adj[SCORE_W+4*i +: 4] = adj[SCORE_W+4*i +: 4] + 4'd3;
    end
    sr_step = {adj[SR_W-2:0], 1'b0};
  end

  // Shift register, step counter and out-of-range flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (load) begin
      sr  <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
      sat <= ({{(32-SCORE_W){1'b0}}, bin} > MAX);
    end else if (state == CONVERT) begin
      sr  <= sr_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign idle = (state == IDLE);
  assign done = (state == DONE);
  assign bcd  = sat ? {NUM_DIGITS{4'd9}} : sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/score_display_engine.sv
// Score overlay: converts, stages and frame-commits digits, then renders pixels.
module score_display_engine
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int SCORE_W      = 8,
  parameter int X0           = 500,
  parameter int Y0           = 96,
  parameter int BLANK_LZ     = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               playing_reg,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic               frame_tick,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic               score_on,
  output logic               busy
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int BOX_W   = GLYPH_W * NUM_DIGITS;
  localparam int BLINK_W = ($clog2(BLINK_FRAMES + 1) > 3) ? $clog2(BLINK_FRAMES + 1) : 3;

  logic               conv_idle, conv_done, conv_start;
  logic [SCORE_W-1:0] conv_bin;
  logic [BCD_W-1:0]   conv_bcd;
  logic               pending;
  logic [SCORE_W-1:0] pending_val;
  logic [BCD_W-1:0]   staged, shown;
  logic [BLINK_W-1:0] blink;

  assign conv_start = (conv_idle && (score_valid || pending)) || (conv_done && pending);
  assign conv_bin   = (conv_idle && score_valid) ? score : pending_val;
  assign busy       = !conv_idle || pending;

  bcd_seq_converter #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .idle  (conv_idle),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // One-deep pending slot for strobes that arrive while the converter is busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= 1'b0;
      pending_val <= '0;
    end else if (score_valid && !conv_idle) begin
      pending     <= 1'b1;
      pending_val <= score;
    end else if (conv_start) begin
      pending     <= 1'b0;
    end
  end

  // Staged digits take the converter result during its DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         staged <= '0;
    else if (conv_done) staged <= conv_bcd;
  end

  // Frame commit of displayed digits and blink countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shown <= '0;
      blink <= '0;
    end else if (frame_tick) begin
      shown <= staged;
      if ((staged != shown) && (BLINK_FRAMES > 0)) blink <= BLINK_W'(BLINK_FRAMES);
      else if (blink != '0)                        blink <= blink - BLINK_W'(1);
    end
  end

  logic [10:0] dx;
  logic [3:0]  dy_low;
  logic        inbox;
  logic [3:0]  digit_val;
  logic        lz_hit, zero_run, blank;

  assign dx     = {1'b0, x} - 11'(X0);
  assign dy_low = 4'({1'b0, y} - 11'(Y0));
  assign inbox  = ({1'b0, x} >= 11'(X0)) && ({1'b0, x} < 11'(X0 + BOX_W)) &&
                  ({1'b0, y} >= 11'(Y0)) && ({1'b0, y} < 11'(Y0 + GLYPH_H));

  // Pick the digit under the pixel and decide leading-zero and blink blanking.
  always_comb begin
    digit_val = 4'd0;
    lz_hit    = 1'b0;
    zero_run  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (shown[BCD_W-1-4*k -: 4] == 4'd0);
      if (dx[10:4] == 7'(k)) begin
        digit_val = playing_reg ? shown[BCD_W-1-4*k -: 4] : 4'd0;
        lz_hit    = zero_run && (k != NUM_DIGITS - 1);
      end
    end
    blank = playing_reg && (((blink != '0) && blink[2]) || ((BLANK_LZ != 0) && lz_hit));
  end

  logic       inbox_s1, blank_s1, inbox_s2, blank_s2, color_data;
  logic [7:0] row_s1;
  logic [3:0] col_s1;

  // Stage 1: ROM address plus box and blank flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inbox_s1 <= 1'b0;
      blank_s1 <= 1'b0;
      row_s1   <= '0;
      col_s1   <= '0;
    end else begin
      inbox_s1 <= inbox;
      blank_s1 <= blank;
      row_s1   <= {digit_val, dy_low};
      col_s1   <= dx[3:0];
    end
  end

  numbers_rom u_rom (
    .clk        (clk),
    .row        (row_s1),
    .col        (col_s1),
    .color_data (color_data)
  );

  // Stage 2: flags delayed to line up with the ROM output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inbox_s2 <= 1'b0;
      blank_s2 <= 1'b0;
    end else begin
      inbox_s2 <= inbox_s1;
      blank_s2 <= blank_s1;
    end
  end

  assign score_on = color_data && inbox_s2 && !blank_s2;

endmodule

// File: tb/tb_score_display_engine.sv
// Scoreboard bench for score_display_engine (3 digits, 11-bit score, blink 32).
module tb_score_display_engine;

  localparam int SW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          playing_reg = 1'b1;
  logic          score_valid = 1'b0;
  logic [SW-1:0] score = '0;
  logic          frame_tick = 1'b0;
  logic [9:0]    x = '0;
  logic [9:0]    y = '0;
  logic          score_on, busy;

  score_display_engine #(
    .NUM_DIGITS(3), .SCORE_W(SW), .X0(500), .Y0(96), .BLANK_LZ(1), .BLINK_FRAMES(32)
  ) dut (
    .clk(clk), .reset(reset), .playing_reg(playing_reg), .score_valid(score_valid),
    .score(score), .frame_tick(frame_tick), .x(x), .y(y),
    .score_on(score_on), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectorCount = 0;
  int missCount = 0;

  int modelStaged = 0;
  int modelShown = 0;
  int modelBlink = 0;
  int modelPlaying = 1;

  typedef struct {
    int cyc;
    int px;
    int py;
    int exp;
  } pix_t;
  pix_t pixQ[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int glyphBit(input int d, input int r, input int c);
    logic [6:0] m;
    bit hTop, hMid, hBot, hCols, vUp, vLo, lft, rgt;
    case (d)
      0: m = 7'b1111110;  1: m = 7'b0110000;  2: m = 7'b1101101;
      3: m = 7'b1111001;  4: m = 7'b0110011;  5: m = 7'b1011011;
      6: m = 7'b1011111;  7: m = 7'b1110000;  8: m = 7'b1111111;
      default: m = 7'b1111011;
    endcase
    hTop = (r == 1) || (r == 2);
    hMid = (r == 7) || (r == 8);
    hBot = (r == 13) || (r == 14);
    hCols = (c >= 3) && (c <= 12);
    vUp = (r >= 1) && (r <= 8);
    vLo = (r >= 7) && (r <= 14);
    lft = (c == 2) || (c == 3);
    rgt = (c == 12) || (c == 13);
    return int'((m[6] && hTop && hCols) || (m[5] && rgt && vUp) || (m[4] && rgt && vLo) ||
                (m[3] && hBot && hCols) || (m[2] && lft && vLo) || (m[1] && lft && vUp) ||
                (m[0] && hMid && hCols));
  endfunction

  function automatic int digitOf(input int v, input int k);
    if (k == 0) return (v / 100) % 10;
    if (k == 1) return (v / 10) % 10;
    return v % 10;
  endfunction

  function automatic int expectPixel(input int px, input int py);
    int k, c, r, d;
    if (px < 500 || px >= 548 || py < 96 || py >= 112) return 0;
    k = (px - 500) / 16;
    c = (px - 500) % 16;
    r = py - 96;
    if (modelPlaying == 0) return glyphBit(0, r, c);
    if (modelBlink != 0 && (modelBlink & 4) != 0) return 0;
    if (k == 0 && digitOf(modelShown, 0) == 0) return 0;
    if (k == 1 && digitOf(modelShown, 0) == 0 && digitOf(modelShown, 1) == 0) return 0;
    d = digitOf(modelShown, k);
    return glyphBit(d, r, c);
  endfunction

  // Compare each pixel on the cycle it is due, two clocks after it was driven.
  always @(negedge clk) begin
    while (pixQ.size() != 0 && pixQ[0].cyc <= cyc) begin
      pix_t e;
      e = pixQ.pop_front();
      checkOutput($sformatf("pix_%0d_%0d", e.px, e.py),
                  (e.cyc == cyc) ? int'(score_on) : -1, e.exp);
    end
  end

  task automatic drivePixel(input int px, input int py);
    pix_t e;
    @(posedge clk); #1;
    x = 10'(px);
    y = 10'(py);
    e.cyc = cyc + 2;
    e.px = px;
    e.py = py;
    e.exp = expectPixel(px, py);
    pixQ.push_back(e);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic scanBox();
    for (int py = 95; py < 113; py++)
      for (int px = 499; px < 549; px++)
        drivePixel(px, py);
    drain();
  endtask

  task automatic applyStimulus(input int val);
    @(posedge clk); #1;
    score_valid = 1'b1;
    score = SW'(val);
    @(posedge clk); #1;
    score_valid = 1'b0;
  endtask

  task automatic waitIdle(input int val);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checkOutput("idle", int'(busy), 0);
    modelStaged = (val > 999) ? 999 : val;
  endtask

  task automatic frameTick();
    drain();
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    if (modelStaged != modelShown) modelBlink = 32;
    else if (modelBlink > 0) modelBlink--;
    modelShown = modelStaged;
  endtask

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_score_on", int'(score_on), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_busy", int'(busy), 0);

    // Leading-zero blanking of 042.
    applyStimulus(42);
    waitIdle(42);
    frameTick();
    scanBox();

    // Saturation: busy exactly SCORE_W+1 cycles, then 999.
    applyStimulus(1234);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checkOutput("sat_busy_cycles", n, 12);
    modelStaged = 999;
    frameTick();
    scanBox();

    // Back-to-back strobes: 77 is overwritten by 5.
    @(posedge clk); #1;
    score_valid = 1'b1;
    score = SW'(10);
    n = 0;
    for (int i = 1; i < 200; i++) begin
      @(posedge clk); #1;
      score_valid = (i == 2) || (i == 5);
      score = (i == 2) ? SW'(77) : SW'(5);
      @(negedge clk);
      if (busy) n++;
      else if (i > 5) break;
    end
    checkOutput("b2b_busy_cycles", n, 24);
    modelStaged = 5;
    frameTick();
    scanBox();

    // No tearing: 8 stays hidden until the next frame tick.
    applyStimulus(9);
    waitIdle(9);
    frameTick();
    scanBox();
    applyStimulus(8);
    waitIdle(8);
    scanBox();
    frameTick();
    scanBox();

    // Blink countdown over the following frames.
    for (int f = 0; f < 33; f++) begin
      frameTick();
      drivePixel(537, 97);
      drivePixel(540, 104);
      drivePixel(528, 100);
    end
    drain();

    // Not playing: always 000, no blanking or blink.
    playing_reg = 1'b0;
    modelPlaying = 0;
    scanBox();
    applyStimulus(77);
    waitIdle(77);
    frameTick();
    scanBox();
    for (int f = 0; f < 32; f++) frameTick();
    playing_reg = 1'b1;
    modelPlaying = 1;

    // Frame tick in the DONE cycle commits the older staged value.
    @(posedge clk); #1;
    score_valid = 1'b1;
    score = SW'(3);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      score_valid = 1'b0;
      frame_tick = (i == 12);
    end
    @(posedge clk); #1;
    frame_tick = 1'b0;
    if (modelBlink > 0) modelBlink--;
    waitIdle(3);
    scanBox();
    frameTick();
    scanBox();

    // Reset in the middle of a conversion discards it.
    for (int f = 0; f < 32; f++) frameTick();
    applyStimulus(55);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_score_on", int'(score_on), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    modelStaged = 0;
    modelShown = 0;
    modelBlink = 0;
    @(posedge clk); #1;
    checkOutput("midrst_busy_after", int'(busy), 0);
    frameTick();
    scanBox();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
